// File: rtl/tinyqv_instr_prefetch.sv
// Instruction prefetch buffer between the QSPI fetch stream and the decoder.
// Optional starvation counter is enabled by defining TINYQV_PREFETCH_PERF_EN.
module tinyqv_instr_prefetch #(
    parameter int                   ADDR_BITS  = 24,
    parameter int                   DEPTH_BITS = 2,
    parameter logic [ADDR_BITS-1:0] RESET_ADDR = '0
) (
    input  logic                  clk,
    input  logic                  rstn,
    output logic [ADDR_BITS-2:0]  instr_addr,
    output logic                  instr_fetch_restart,
    output logic                  instr_fetch_stall,
    input  logic                  instr_fetch_started,
    input  logic                  instr_fetch_stopped,
    input  logic [15:0]           instr_data_in,
    input  logic                  instr_ready,
    output logic [31:0]           instr,
    output logic                  instr_valid,
    input  logic [2:1]            instr_len,
    input  logic                  instr_complete,
    input  logic                  branch,
    input  logic [ADDR_BITS-1:0]  branch_addr,
    output logic [ADDR_BITS-1:0]  pc,
    output logic [DEPTH_BITS:0]   avail
`ifdef TINYQV_PREFETCH_PERF_EN
    ,
    output logic [15:0]           starve_count
`endif
);
    // Fetch side: a halfword is accepted when instr_ready is high, the stream is
    // running, no branch is present and a slot is free after this cycle's consume.
    // Consume side: instr_valid advertises a whole instruction at rd; the core
    // consumes it by pulsing instr_complete with instr_len halfwords.
    localparam int              DEPTH = 1 << DEPTH_BITS;
    localparam int              PW    = DEPTH_BITS + 1;
    localparam logic [PW-1:0]   FULL  = PW'(DEPTH);

    logic [15:0]           r_buf [DEPTH];
    logic [PW-1:0]         r_rd;
    logic [PW-1:0]         r_wr;
    logic [ADDR_BITS-1:0]  r_pc;
    logic                  r_fetch_running;

    logic [PW-1:0]         w_avail;
    logic [PW-1:0]         w_len;
    logic [PW-1:0]         w_cons_n;
    logic [PW-1:0]         w_avail_next;
    logic                  w_consume;
    logic                  w_wr_en;
    logic                  w_valid;
    logic [DEPTH_BITS-1:0] w_rd_idx;
    logic [DEPTH_BITS-1:0] w_rd_idx1;
    logic                  w_unused_ok;

    assign w_unused_ok = branch_addr[0];

    assign w_avail   = r_wr - r_rd;
    assign w_len     = PW'(instr_len);
    assign w_consume = instr_complete && !branch && (w_len != '0) && (w_len <= w_avail);
    assign w_cons_n  = w_consume ? w_len : '0;
    // A slot freed by a same-cycle consume may be refilled in that cycle.
    assign w_wr_en      = instr_ready && r_fetch_running && !branch &&
                          ((w_avail - w_cons_n) != FULL);
    assign w_avail_next = branch ? '0 : (w_avail + PW'(w_wr_en) - w_cons_n);

    assign w_rd_idx  = r_rd[DEPTH_BITS-1:0];
    assign w_rd_idx1 = w_rd_idx + DEPTH_BITS'(1);
    assign w_valid   = (w_avail >= PW'(2)) ||
                       ((w_avail == PW'(1)) && (r_buf[w_rd_idx][1:0] != 2'b11));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rd            <= '0;
            r_wr            <= '0;
            r_pc            <= {RESET_ADDR[ADDR_BITS-1:1], 1'b0};
            r_fetch_running <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_buf[i] <= '0;
            end
        end else if (branch) begin
            r_rd            <= '0;
            r_wr            <= '0;
            r_pc            <= {branch_addr[ADDR_BITS-1:1], 1'b0};
            r_fetch_running <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_buf[r_wr[DEPTH_BITS-1:0]] <= instr_data_in;
                r_wr                        <= r_wr + PW'(1);
            end
            r_rd <= r_rd + w_cons_n;
            r_pc <= r_pc + ADDR_BITS'({w_cons_n, 1'b0});
            if (instr_fetch_started) begin
                r_fetch_running <= 1'b1;
            end else if (instr_fetch_stopped) begin
                r_fetch_running <= 1'b0;
            end
        end
    end

`ifdef TINYQV_PREFETCH_PERF_EN
    logic [15:0] r_starve;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_starve <= '0;
        end else if (r_fetch_running && !w_valid && !branch && (r_starve != 16'hFFFF)) begin
            r_starve <= r_starve + 16'd1;
        end
    end

    assign starve_count = r_starve;
`endif

    assign instr_addr          = r_pc[ADDR_BITS-1:1] + (ADDR_BITS-1)'(w_avail);
    assign instr_fetch_restart = !r_fetch_running;
    assign instr_fetch_stall   = (w_avail_next == FULL);
    assign instr               = {r_buf[w_rd_idx1], r_buf[w_rd_idx]};
    assign instr_valid         = w_valid;
    assign pc                  = r_pc;
    assign avail               = w_avail;

endmodule
